axis_lrelu_config_packer: RTL and testbench
===========================================

Name: axis_lrelu_config_packer

Overview:
- Transmit-side packer for the LReLU engine input stream.
- Per layer it emits config beats followed by conv-output data beats, so the downstream engine's config phase and data phase are fed in order.
- Merges a config source stream and a conv-core data stream into one AXIS master (tdata/tuser/tlast) that drives the engine's slave port.
- Sits between the conv core / config DMA and the LReLU engine.

Parameters:
- WORD_WIDTH_IN, 32, word width of one conv output.
- UNITS, 8; GROUPS, 2; COPIES, 2; MEMBERS, 2; array dimensions.
- DATA_W, MEMBERS*COPIES*GROUPS*UNITS*WORD_WIDTH_IN, beat width (1024 at defaults).
- BITS_CONV_CORE, $clog2(GROUPS*COPIES*MEMBERS), low tuser bits.
- I_IS_3X3, BITS_CONV_CORE, tuser index of the 3x3 flag.
- TUSER_WIDTH_LRELU, BITS_CONV_CORE+8, tuser width.
- CONFIG_BEATS_3X3, 21, total config beats per 3x3 layer.
- CONFIG_BEATS_1X1, 10, total config beats per 1x1 layer.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_config_tvalid  in  1  config beat valid.
- s_config_tready  out  1  config beat ready.
- s_config_tdata  in  DATA_W  config payload.
- s_config_is_3x3  in  1  layer mode; sampled on the first config beat of each layer.
- s_data_tvalid  in  1  conv data valid.
- s_data_tready  out  1  conv data ready.
- s_data_tdata  in  DATA_W  conv data.
- s_data_tuser  in  TUSER_WIDTH_LRELU  conv data user bits.
- s_data_tlast  in  1  last data beat of the layer.
- m_axis_tvalid  out  1  packed stream valid.
- m_axis_tready  in  1  packed stream ready.
- m_axis_tdata  out  DATA_W  packed data.
- m_axis_tuser  out  TUSER_WIDTH_LRELU  packed user bits.
- m_axis_tlast  out  1  packed last.

Behaviour:
- Reset: asynchronous on aresetn low. State <= HDR; counter <= 0; mode <= 0; output slice empty.
- Output values while in reset: m_axis_tvalid=0, tdata=0, tuser=0, tlast=0, s_config_tready=0, s_data_tready=0.
- Output stage: 2-entry skid register slice. Full throughput; 1-cycle latency from input handshake to m_axis_tvalid. Its ready (slice_rdy) is registered (no combinational path from m_axis_tready to either s_*_tready).
- FSM states:
  - HDR: s_config_tready=slice_rdy, s_data_tready=0. On config handshake: mode<=s_config_is_3x3; counter<=(is_3x3 ? CONFIG_BEATS_3X3 : CONFIG_BEATS_1X1)-2; push beat; go to CFG.
  - CFG: s_config_tready=slice_rdy, s_data_tready=0. Each config handshake pushes a beat and decrements counter. Handshake with counter==0 goes to DATA.
  - DATA: s_data_tready=slice_rdy, s_config_tready=0. Data beats are forwarded unchanged (tdata, tuser, tlast). A handshake with s_data_tlast=1 goes to HDR.
- Config beat output fields: tdata=s_config_tdata; tuser[I_IS_3X3]=mode, where mode is s_config_is_3x3 on the first beat and the latched value afterwards; all other tuser bits 0; tlast=0.
- s_config_is_3x3 is ignored on every config beat after the first of a layer.
- Beat counts per layer are exactly CONFIG_BEATS_3X3 or CONFIG_BEATS_1X1 config beats, then data through tlast.
- Data arriving during HDR/CFG stalls (tready=0). Config arriving during DATA stalls.
- Counter width is $clog2(CONFIG_BEATS_3X3). Counter never wraps: it is loaded only in HDR.
- A single-beat data layer (tlast on the first data beat) returns to HDR after 1 beat.
- Backpressure: m_axis_tready=0 for any duration loses and duplicates no beat. Outputs hold while m_axis_tvalid=1 && !m_axis_tready.
- Reset mid-layer: everything returns to HDR and the slice is flushed. Upstream must restart from a layer boundary.

Optional Feature:
- Macro: AXIS_LRELU_CONFIG_PACKER_CHECK_EN.
- Enabled: adds output err_mode_mismatch (1 bit, sticky, reset 0). It sets on any DATA-state handshake where s_data_tuser[I_IS_3X3] != mode, and clears only on reset.
- Disabled: the port and its logic are absent; data tuser is forwarded unchecked.

Test Plan:
- 3x3 layer: 21 config beats (first beat is_3x3=1), then 5 data beats with tlast on beat 5, m_axis_tready=1.
  -> 26 output beats in order; tuser[I_IS_3X3]=1 on all config beats; tlast only on output beat 26; state back in HDR.
- 1x1 layer: 10 config beats with is_3x3=0, then 3 data beats.
  -> s_config_tready drops after the 10th config handshake; the 11th config word is held until the data tlast is accepted.
- Interleaving: data valid asserted before config finishes.
  -> s_data_tready=0 until 21 config beats have handshaken; then data flows; no data beat precedes a config beat.
- Random m_axis_tready (50%) over 3 back-to-back layers (3x3, 1x1, 3x3).
  -> scoreboard matches exactly; no drop or duplicate; outputs stable while stalled.
- aresetn pulsed low at config beat 7 of a 3x3 layer.
  -> m_axis_tvalid=0 immediately; after release, a fresh 21-beat config sequence is required.
- CHECK_EN built: mode=1, data beat with tuser[I_IS_3X3]=0.
  -> err_mode_mismatch=1 the next cycle and stays 1 until reset.

Source files
------------

// File: rtl/axis_lrelu_config_packer.sv
// rtl/axis_lrelu_config_packer.sv - merges per-layer config beats and conv data beats into one AXIS stream for the LReLU engine; optional feature macro AXIS_LRELU_CONFIG_PACKER_CHECK_EN adds err_mode_mismatch
module axis_lrelu_config_packer #(
    parameter int WORD_WIDTH_IN     = 32,
    parameter int UNITS             = 8,
    parameter int GROUPS            = 2,
    parameter int COPIES            = 2,
    parameter int MEMBERS           = 2,
    parameter int DATA_W            = MEMBERS*COPIES*GROUPS*UNITS*WORD_WIDTH_IN,
    parameter int BITS_CONV_CORE    = $clog2(GROUPS*COPIES*MEMBERS),
    parameter int I_IS_3X3          = BITS_CONV_CORE,
    parameter int TUSER_WIDTH_LRELU = BITS_CONV_CORE + 8,
    parameter int CONFIG_BEATS_3X3  = 21,
    parameter int CONFIG_BEATS_1X1  = 10
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         s_config_tvalid,
    output logic                         s_config_tready,
    input  logic [DATA_W-1:0]            s_config_tdata,
    input  logic                         s_config_is_3x3,
    input  logic                         s_data_tvalid,
    output logic                         s_data_tready,
    input  logic [DATA_W-1:0]            s_data_tdata,
    input  logic [TUSER_WIDTH_LRELU-1:0] s_data_tuser,
    input  logic                         s_data_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_W-1:0]            m_axis_tdata,
    output logic [TUSER_WIDTH_LRELU-1:0] m_axis_tuser,
    output logic                         m_axis_tlast
`ifdef AXIS_LRELU_CONFIG_PACKER_CHECK_EN
    ,
    output logic                         err_mode_mismatch
`endif
);

    localparam int CNT_W = $clog2(CONFIG_BEATS_3X3);

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_CFG  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                         state_q;
    logic [CNT_W-1:0]               cnt_q;
    logic                           mode_q;

    // Output slice: primary (visible) register plus one skid entry.
    logic                           out_valid_q, out_valid_d;
    logic [DATA_W-1:0]              out_data_q, out_data_d;
    logic [TUSER_WIDTH_LRELU-1:0]   out_user_q, out_user_d;
    logic                           out_last_q, out_last_d;
    logic                           skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0]              skid_data_q, skid_data_d;
    logic [TUSER_WIDTH_LRELU-1:0]   skid_user_q, skid_user_d;
    logic                           skid_last_q, skid_last_d;
    logic                           slice_rdy_q, slice_rdy_d;

    logic                           sel_data;
    logic                           cfg_fire;
    logic                           dat_fire;
    logic                           push;
    logic                           out_fire;
    logic                           cfg_mode;
    logic [DATA_W-1:0]              push_data;
    logic [TUSER_WIDTH_LRELU-1:0]   push_user;
    logic                           push_last;

    // Only one source is ever offered ready, so the two handshakes are exclusive.
    assign sel_data        = (state_q == ST_DATA);
    assign s_config_tready = !sel_data && slice_rdy_q;
    assign s_data_tready   = sel_data && slice_rdy_q;
    assign cfg_fire        = s_config_tvalid && s_config_tready;
    assign dat_fire        = s_data_tvalid && s_data_tready;
    assign push            = cfg_fire || dat_fire;
    assign out_fire        = out_valid_q && m_axis_tready;

    // The first config beat of a layer carries its own mode; later ones use the latched copy.
    assign cfg_mode = (state_q == ST_HDR) ? s_config_is_3x3 : mode_q;

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tuser  = out_user_q;
    assign m_axis_tlast  = out_last_q;

    // Select the beat offered to the output slice: forwarded data or a formatted config beat.
    always_comb begin
        push_data = s_config_tdata;
        push_user = '0;
        push_last = 1'b0;
        if (sel_data) begin
            push_data = s_data_tdata;
            push_user = s_data_tuser;
            push_last = s_data_tlast;
        end else begin
            push_user[I_IS_3X3] = cfg_mode;
        end
    end

    // Layer sequencer: header beat, remaining config beats, then data through tlast.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_HDR;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_HDR: begin
                    if (cfg_fire) begin
                        mode_q  <= s_config_is_3x3;
                        cnt_q   <= s_config_is_3x3 ? CNT_W'(CONFIG_BEATS_3X3 - 2)
                                                   : CNT_W'(CONFIG_BEATS_1X1 - 2);
                        state_q <= ST_CFG;
                    end
                end
                ST_CFG: begin
                    if (cfg_fire) begin
                        if (cnt_q == '0) begin
                            state_q <= ST_DATA;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (dat_fire && s_data_tlast) begin
                        state_q <= ST_HDR;
                    end
                end
                default: state_q <= ST_HDR;
            endcase
        end
    end

    // Skid slice next state: the skid entry only fills when a beat arrives while the output is stalled.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_user_d   = out_user_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_user_d  = skid_user_q;
        skid_last_d  = skid_last_q;
        if (skid_valid_q) begin
            if (out_fire) begin
                out_data_d   = skid_data_q;
                out_user_d   = skid_user_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!out_valid_q || out_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = push_data;
                out_user_d  = push_user;
                out_last_d  = push_last;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = push_data;
                skid_user_d  = push_user;
                skid_last_d  = push_last;
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
        // Ready is registered so m_axis_tready never reaches the upstream readies combinationally.
        slice_rdy_d = !skid_valid_d;
    end

    // Skid slice registers; ready stays low while in reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_user_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_user_q  <= '0;
            skid_last_q  <= 1'b0;
            slice_rdy_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_user_q   <= out_user_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_user_q  <= skid_user_d;
            skid_last_q  <= skid_last_d;
            slice_rdy_q  <= slice_rdy_d;
        end
    end

`ifdef AXIS_LRELU_CONFIG_PACKER_CHECK_EN
    logic err_q;

    // Sticky flag: a data beat whose 3x3 flag disagrees with the layer mode.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else if (dat_fire && (s_data_tuser[I_IS_3X3] != mode_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err_mode_mismatch = err_q;
`endif

endmodule

// File: tb/tb_axis_lrelu_config_packer.sv
// tb/tb_axis_lrelu_config_packer.sv - randomized scoreboard bench for axis_lrelu_config_packer
module tb_axis_lrelu_config_packer;

    localparam int DW = 1024;
    localparam int UW = 11;
    localparam int I3 = 3;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic          s_config_tvalid = 1'b0;
    logic          s_config_tready;
    logic [DW-1:0] s_config_tdata = '0;
    logic          s_config_is_3x3 = 1'b0;
    logic          s_data_tvalid = 1'b0;
    logic          s_data_tready;
    logic [DW-1:0] s_data_tdata = '0;
    logic [UW-1:0] s_data_tuser = '0;
    logic          s_data_tlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [DW-1:0] m_axis_tdata;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tlast;
`ifdef AXIS_LRELU_CONFIG_PACKER_CHECK_EN
    logic          err_mode_mismatch;
`endif

    always #5 aclk = ~aclk;

    axis_lrelu_config_packer dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_config_tvalid (s_config_tvalid),
        .s_config_tready (s_config_tready),
        .s_config_tdata  (s_config_tdata),
        .s_config_is_3x3 (s_config_is_3x3),
        .s_data_tvalid   (s_data_tvalid),
        .s_data_tready   (s_data_tready),
        .s_data_tdata    (s_data_tdata),
        .s_data_tuser    (s_data_tuser),
        .s_data_tlast    (s_data_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tlast    (m_axis_tlast)
`ifdef AXIS_LRELU_CONFIG_PACKER_CHECK_EN
        ,
        .err_mode_mismatch (err_mode_mismatch)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Stimulus queues and the expected packed stream.
    logic [DW-1:0] cq_w[$];
    logic          cq_m[$];
    logic [DW-1:0] dq_w[$];
    logic [UW-1:0] dq_u[$];
    logic          dq_l[$];
    logic [DW-1:0] ex_d[$];
    logic [UW-1:0] ex_u[$];
    logic          ex_l[$];

    bit mon_en = 0;
    bit rnd_rdy = 0;
    int cfg_hs = 0;
    int dat_hs = 0;
    int out_cnt = 0;
    int last_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // A layer is N config beats carrying the mode in tuser, then nd data beats passed through.
    task automatic add_layer(input bit m, input int nd);
        int n;
        logic [DW-1:0] w;
        logic [UW-1:0] u;
        n = m ? 21 : 10;
        for (int i = 0; i < n; i++) begin
            w = rand_word();
            cq_w.push_back(w);
            cq_m.push_back((i == 0) ? m : 1'($urandom_range(0, 1)));
            ex_d.push_back(w);
            ex_u.push_back(UW'(m) << I3);
            ex_l.push_back(1'b0);
        end
        for (int j = 0; j < nd; j++) begin
            w = rand_word();
            u = UW'($urandom);
            u[I3] = m;
            dq_w.push_back(w); dq_u.push_back(u); dq_l.push_back(j == nd - 1);
            ex_d.push_back(w); ex_u.push_back(u); ex_l.push_back(j == nd - 1);
        end
    endtask

    task automatic hs_cfg(input logic [DW-1:0] w, input logic m, output bit ok);
        int t;
        s_config_tvalid = 1'b1;
        s_config_tdata  = w;
        s_config_is_3x3 = m;
        ok = 0;
        t = 0;
        while (!ok && t < 2000) begin
            @(negedge aclk);
            if (s_config_tready) ok = 1;
            t++;
        end
        if (ok) begin
            @(posedge aclk);
            #1;
            cfg_hs++;
        end else begin
            checks++; errors++;
            $display("FAIL cfg_timeout: got no s_config_tready expected handshake");
        end
    endtask

    task automatic drive_cfg(input int gap_max);
        bit ok;
        while (cq_w.size() > 0) begin
            if (gap_max > 0) begin
                s_config_tvalid = 1'b0;
                repeat ($urandom_range(0, gap_max)) begin @(posedge aclk); #1; end
            end
            hs_cfg(cq_w[0], cq_m[0], ok);
            if (!ok) begin cq_w.delete(); cq_m.delete(); end
            else begin void'(cq_w.pop_front()); void'(cq_m.pop_front()); end
        end
        s_config_tvalid = 1'b0;
    endtask

    task automatic drive_dat(input int delay, input int gap_max);
        int t;
        bit ok;
        repeat (delay) begin @(posedge aclk); #1; end
        while (dq_w.size() > 0) begin
            if (gap_max > 0) begin
                s_data_tvalid = 1'b0;
                repeat ($urandom_range(0, gap_max)) begin @(posedge aclk); #1; end
            end
            s_data_tvalid = 1'b1;
            s_data_tdata  = dq_w[0];
            s_data_tuser  = dq_u[0];
            s_data_tlast  = dq_l[0];
            ok = 0;
            t = 0;
            while (!ok && t < 2000) begin
                @(negedge aclk);
                if (s_data_tready) ok = 1;
                t++;
            end
            if (ok) begin
                @(posedge aclk);
                #1;
                dat_hs++;
                void'(dq_w.pop_front()); void'(dq_u.pop_front()); void'(dq_l.pop_front());
            end else begin
                checks++; errors++;
                $display("FAIL dat_timeout: got no s_data_tready expected handshake");
                dq_w.delete(); dq_u.delete(); dq_l.delete();
            end
        end
        s_data_tvalid = 1'b0;
        s_data_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (ex_d.size() > 0 && t < 5000) begin @(posedge aclk); t++; end
        #1;
        check("drain_remaining", 64'(ex_d.size()), 64'd0);
        ex_d.delete(); ex_u.delete(); ex_l.delete();
    endtask

    // Sink ready: always 1, or a fair coin each cycle.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: hold-while-stalled and in-order scoreboard on every accepted beat.
    initial begin
        bit            prev_stall;
        logic [DW-1:0] pd;
        logic [UW-1:0] pu;
        logic          pl;
        prev_stall = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 0;
            end else if (mon_en) begin
                if (prev_stall) begin
                    checks++;
                    if (!(m_axis_tvalid && m_axis_tdata == pd && m_axis_tuser == pu && m_axis_tlast == pl)) begin
                        errors++;
                        $display("FAIL hold_stable: got v=%0b u=%0h l=%0b d=%0h expected v=1 u=%0h l=%0b d=%0h",
                                 m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata[31:0], pu, pl, pd[31:0]);
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    checks++;
                    out_cnt++;
                    if (m_axis_tlast) last_idx = out_cnt;
                    if (ex_d.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat: got unexpected beat d=%0h expected none", m_axis_tdata[31:0]);
                    end else begin
                        if (m_axis_tdata !== ex_d[0] || m_axis_tuser !== ex_u[0] || m_axis_tlast !== ex_l[0]) begin
                            errors++;
                            $display("FAIL beat_%0d: got d=%0h u=%0h l=%0b expected d=%0h u=%0h l=%0b", out_cnt,
                                     m_axis_tdata[31:0], m_axis_tuser, m_axis_tlast, ex_d[0][31:0], ex_u[0], ex_l[0]);
                        end
                        void'(ex_d.pop_front()); void'(ex_u.pop_front()); void'(ex_l.pop_front());
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                pd = m_axis_tdata; pu = m_axis_tuser; pl = m_axis_tlast;
            end
        end
    end

    initial begin
        int base;
        bit ok;

        // Reset values
        #2 aresetn = 1'b0;
        @(negedge aclk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata[63:0]), 64'd0);
        check("rst_tuser", 64'(m_axis_tuser), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_cfg_ready", 64'(s_config_tready), 64'd0);
        check("rst_dat_ready", 64'(s_data_tready), 64'd0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        mon_en = 1;

        // 3x3 layer, 5 data beats, sink always ready
        add_layer(1'b1, 5);
        check("model_len", 64'(ex_d.size()), 64'd26);
        check("model_cfg_flag", 64'(ex_u[0]), 64'h8);
        check("model_cfg20_last", 64'(ex_l[20]), 64'd0);
        check("model_beat26_last", 64'(ex_l[25]), 64'd1);
        out_cnt = 0;
        fork
            drive_cfg(0);
            drive_dat(0, 0);
        join
        drain();
        check("t1_out_count", 64'(out_cnt), 64'd26);
        check("t1_tlast_index", 64'(last_idx), 64'd26);
        @(negedge aclk);
        check("t1_hdr_dat_ready", 64'(s_data_tready), 64'd0);
        check("t1_hdr_cfg_ready", 64'(s_config_tready), 64'd1);
        @(posedge aclk); #1;

        // 1x1 layer with next layer's config waiting; data held back
        base = cfg_hs;
        add_layer(1'b0, 3);
        add_layer(1'b1, 2);
        fork
            drive_cfg(0);
            drive_dat(30, 0);
            begin
                int t;
                t = 0;
                while (cfg_hs < base + 10 && t < 200) begin @(posedge aclk); t++; end
                check("t2_cfg_hs_count", 64'(cfg_hs - base), 64'd10);
                repeat (4) begin
                    @(negedge aclk);
                    check("t2_cfg11_held", 64'(s_config_tready), 64'd0);
                end
            end
        join
        drain();

        // Data offered before config completes
        add_layer(1'b1, 4);
        fork
            drive_cfg(1);
            drive_dat(0, 0);
            begin
                repeat (5) begin
                    @(negedge aclk);
                    check("t3_data_stalled", 64'(s_data_tready), 64'd0);
                end
            end
        join
        drain();

        // Random sink backpressure over three layers
        rnd_rdy = 1;
        add_layer(1'b1, 6);
        add_layer(1'b0, 3);
        add_layer(1'b1, 5);
        fork
            drive_cfg(2);
            drive_dat(0, 2);
        join
        drain();
        rnd_rdy = 0;
        @(posedge aclk); #1;

        // Reset during config beat 7 of a 3x3 layer
        mon_en = 0;
        for (int k = 0; k < 6; k++) begin
            hs_cfg(rand_word(), 1'b1, ok);
        end
        s_config_tvalid = 1'b1;
        s_config_tdata  = rand_word();
        check("t5_valid_before_rst", 64'(m_axis_tvalid), 64'd1);
        #1 aresetn = 1'b0;
        #1;
        check("t5_valid_in_rst", 64'(m_axis_tvalid), 64'd0);
        check("t5_cfg_ready_in_rst", 64'(s_config_tready), 64'd0);
        s_config_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        mon_en = 1;
        out_cnt = 0;
        add_layer(1'b1, 3);
        fork
            drive_cfg(0);
            drive_dat(0, 0);
        join
        drain();
        check("t5_fresh_layer_count", 64'(out_cnt), 64'd24);

`ifdef AXIS_LRELU_CONFIG_PACKER_CHECK_EN
        // Mode mismatch flag is sticky until reset
        check("t6_err_clear", 64'(err_mode_mismatch), 64'd0);
        add_layer(1'b1, 2);
        dq_u[0][I3] = 1'b0;
        ex_u[ex_u.size()-2][I3] = 1'b0;
        fork
            drive_cfg(0);
            drive_dat(0, 0);
        join
        drain();
        check("t6_err_set", 64'(err_mode_mismatch), 64'd1);
        repeat (5) @(posedge aclk);
        #1;
        check("t6_err_sticky", 64'(err_mode_mismatch), 64'd1);
        aresetn = 1'b0;
        #1;
        check("t6_err_reset", 64'(err_mode_mismatch), 64'd0);
        @(posedge aclk); #1 aresetn = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
